seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It holds a BCD display word, cycles one active-low anode at a time with a configurable dwell and a ghost-suppression blanking gap, and drives the shared segment bus with the matching glyph. It sits between the value-producing logic (counters, measurement blocks) and the board display pins. It replaces per-digit static decoders where pin count forbids them.

---
 rtl/seg_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: blank gap then dwell per digit, shadowed BCD word committed at frame end.
// Outputs registered from the next state; define LEADING_ZERO_SUPPRESS_EN to blank leading zeros.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        frame_end;

  logic [NUM_DIGITS-1:0][3:0]  shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]       shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0][3:0]  active_bcd_q, active_bcd_d;
  logic [NUM_DIGITS-1:0]       active_dp_q, active_dp_d;
  logic                        pending_q, pending_d;
  logic                        commit;

  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        dp_q, dp_d;
  logic                        frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]       lz_mask;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Dropping enable overrides every state and aborts the frame without a frame_done.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d     = '0;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Commit reads the old shadow, so a load in the commit cycle stays pending.
  always_comb begin
    commit       = pending_q && ((state_q == ST_IDLE) || frame_end);
    active_bcd_d = commit ? shadow_bcd_q : active_bcd_q;
    active_dp_d  = commit ? shadow_dp_q  : active_dp_q;
    shadow_bcd_d = load ? bcd_in : shadow_bcd_q;
    shadow_dp_d  = load ? dp_in  : shadow_dp_q;
    if (load) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

`ifdef LEADING_ZERO_SUPPRESS_EN
  logic lz_above;
  always_comb begin
    lz_above = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_mask[i] = lz_above && (active_bcd_d[i] == 4'd0);
      lz_above   = lz_above && ((active_bcd_d[i] == 4'd0) || (active_bcd_d[i] >= 4'd10));
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    an_d         = '1;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = frame_end;
    if (state_d == ST_SHOW) begin
      an_d[idx_d] = 1'b0;
      seg_d       = lz_mask[idx_d] ? 7'h7F : glyph(active_bcd_d[idx_d]);
      dp_d        = ~active_dp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_bcd_q <= '1;
      shadow_dp_q  <= '0;
      active_bcd_q <= '1;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      active_bcd_q <= active_bcd_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table vectors, hand sequences and random traffic against a time-based model.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int DW    = 4;
  localparam int BL    = 1;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst, enable, load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] glyph_tab [16];

  // Model: time since scanning started decides which digit is lit; data moves shadow->active on commit events.
  bit          m_run;
  int          m_t;
  logic [15:0] m_sh_bcd, m_ac_bcd;
  logic [3:0]  m_sh_dp, m_ac_dp;
  bit          m_pend, m_fd;

  typedef struct packed {
    logic [15:0]     bcd;
    logic [3:0]      dpv;
    logic [3:0][6:0] seg_e;
    logic [3:0]      dp_e;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit lz_blank(input int d);
`ifdef LEADING_ZERO_SUPPRESS_EN
    if (d == 0 || m_ac_bcd[4*d +: 4] != 4'd0) return 1'b0;
    for (int j = d + 1; j < ND; j++)
      if (m_ac_bcd[4*j +: 4] inside {[4'd1:4'd9]}) return 1'b0;
    return 1'b1;
`else
    return (d < 0);
`endif
  endfunction

  task automatic model_edge();
    bit was_idle, cmt;
    if (rst) begin
      m_run = 0; m_t = 0; m_pend = 0; m_fd = 0;
      m_ac_bcd = 16'hFFFF; m_ac_dp = 4'h0;
      m_sh_bcd = 16'hFFFF; m_sh_dp = 4'h0;
    end else begin
      was_idle = !m_run;
      if (!enable) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0;
      end else begin
        m_t++;
      end
      m_fd = m_run && (m_t > 0) && (m_t % FRAME == 0);
      cmt  = m_pend && (was_idle || m_fd);
      if (cmt) begin
        m_ac_bcd = m_sh_bcd;
        m_ac_dp  = m_sh_dp;
      end
      if (load) begin
        m_sh_bcd = bcd_in; m_sh_dp = dp_in; m_pend = 1;
      end else if (cmt) begin
        m_pend = 0;
      end
    end
  endtask

  task automatic step();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         d;
    @(posedge clk);
    model_edge();
    #1;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (m_run && (m_t % SLOT) >= BL) begin
      d     = (m_t / SLOT) % ND;
      e_an  = 4'hF ^ (4'b0001 << d);
      e_seg = lz_blank(d) ? 7'h7F : glyph_tab[m_ac_bcd[4*d +: 4]];
      e_dp  = ~m_ac_dp[d];
    end
    check("model_an", an, e_an);
    check("model_seg", seg, e_seg);
    check("model_dp", dp, e_dp);
    check("model_frame_done", frame_done, m_fd);
  endtask

  // Leaves the DUT idle with the given word committed.
  task automatic preload(input logic [15:0] b, input logic [3:0] p);
    enable = 0; step();
    load = 1; bcd_in = b; dp_in = p; step();
    load = 0; step();
  endtask

  initial begin
    int fd_cnt;
    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    vecs[0] = '{bcd: 16'h1234, dpv: 4'b0100, seg_e: {7'h79, 7'h24, 7'h30, 7'h19}, dp_e: 4'b1011};
    vecs[3] = '{bcd: 16'h5678, dpv: 4'b1001, seg_e: {7'h12, 7'h02, 7'h78, 7'h00}, dp_e: 4'b0110};
    vecs[4] = '{bcd: 16'h9F0E, dpv: 4'b0010, seg_e: {7'h10, 7'h7F, 7'h40, 7'h7F}, dp_e: 4'b1101};
`ifdef LEADING_ZERO_SUPPRESS_EN
    vecs[1] = '{bcd: 16'h0007, dpv: 4'b0000, seg_e: {7'h7F, 7'h7F, 7'h7F, 7'h78}, dp_e: 4'b1111};
    vecs[2] = '{bcd: 16'h000A, dpv: 4'b0001, seg_e: {7'h7F, 7'h7F, 7'h7F, 7'h7F}, dp_e: 4'b1110};
    vecs[5] = '{bcd: 16'h0100, dpv: 4'b0000, seg_e: {7'h7F, 7'h79, 7'h40, 7'h40}, dp_e: 4'b1111};
`else
    vecs[1] = '{bcd: 16'h0007, dpv: 4'b0000, seg_e: {7'h40, 7'h40, 7'h40, 7'h78}, dp_e: 4'b1111};
    vecs[2] = '{bcd: 16'h000A, dpv: 4'b0001, seg_e: {7'h40, 7'h40, 7'h40, 7'h7F}, dp_e: 4'b1110};
    vecs[5] = '{bcd: 16'h0100, dpv: 4'b0000, seg_e: {7'h40, 7'h79, 7'h40, 7'h40}, dp_e: 4'b1111};
`endif

    rst = 1; enable = 0; load = 0; bcd_in = '0; dp_in = '0;
    step(); step();
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    check("reset_frame_done", frame_done, 1'b0);

    // Free-running scan with the reset word (all blank glyphs).
    rst = 0; enable = 1; fd_cnt = 0;
    for (int t = 0; t <= 2 * FRAME; t++) begin
      step();
      if (frame_done) fd_cnt++;
      if (t == 1)  check("first_digit_an", an, 4'b1110);
      if (t == 16) check("digit3_an", an, 4'b0111);
      if (t == 15) check("gap_an", an, 4'hF);
      if (t == 2)  check("reset_word_seg", seg, 7'h7F);
      if (t == FRAME) check("frame_done_t20", frame_done, 1'b1);
    end
    check("frame_done_count", fd_cnt, 2);

    foreach (vecs[i]) begin
      preload(vecs[i].bcd, vecs[i].dpv);
      enable = 1;
      for (int t = 0; t < FRAME; t++) begin
        step();
        if (t % SLOT == 3) begin
          check("vec_seg", seg, vecs[i].seg_e[t / SLOT]);
          check("vec_dp", dp, vecs[i].dp_e[t / SLOT]);
          check("vec_an", an, 4'hF ^ (4'b0001 << (t / SLOT)));
        end
      end
    end

    // Mid-frame load stays hidden until the next frame.
    preload(16'h1234, 4'b0100);
    enable = 1;
    for (int t = 0; t < 25; t++) begin
      load = (t == 6); bcd_in = 16'h5678; dp_in = 4'b0000;
      step();
      if (t == 12) check("midload_digit2_old", seg, 7'h24);
      if (t == 17) check("midload_digit3_old", seg, 7'h79);
      if (t == 19) check("midload_no_early_fd", frame_done, 1'b0);
      if (t == 20) check("midload_fd", frame_done, 1'b1);
      if (t == 22) check("midload_digit0_new", seg, 7'h00);
    end
    load = 0;

    // Enable drop during digit2 SHOW, then restart.
    for (int t = 25; t < 33; t++) begin
      enable = (t != 32);
      step();
    end
    check("drop_an", an, 4'hF);
    check("drop_seg", seg, 7'h7F);
    check("drop_fd", frame_done, 1'b0);
    step(); step();
    enable = 1;
    step();
    check("restart_blank_an", an, 4'hF);
    step();
    check("restart_digit0_an", an, 4'b1110);

    // Several loads in one frame, last wins; a load on the commit edge waits a frame.
    preload(16'h1111, 4'b0000);
    enable = 1;
    for (int t = 0; t < 44; t++) begin
      load = (t == 5) || (t == 10) || (t == FRAME);
      bcd_in = (t == 5) ? 16'h2222 : (t == 10) ? 16'h3333 : 16'h4444;
      step();
      if (t == 2)  check("multi_old", seg, 7'h79);
      if (t == 22) check("multi_last_wins", seg, 7'h30);
      if (t == 42) check("multi_commit_edge_load", seg, 7'h19);
    end
    load = 0;

    // Reset mid-SHOW with a simultaneous load.
    preload(16'h1234, 4'b0100);
    enable = 1;
    for (int t = 0; t < 8; t++) step();
    rst = 1; load = 1; bcd_in = 16'h5678; dp_in = 4'hF;
    step();
    check("rst_load_an", an, 4'hF);
    check("rst_load_seg", seg, 7'h7F);
    check("rst_load_dp", dp, 1'b1);
    rst = 0; load = 0;
    for (int t = 0; t < 24; t++) begin
      step();
      if (t == 2)  check("rst_running_an", an, 4'b1110);
      if (t == 2)  check("rst_active_blank", seg, 7'h7F);
      if (t == 22) check("rst_no_pending", seg, 7'h7F);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 499) == 0);
      enable = ($urandom_range(0, 99) != 0);
      load   = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < ND; k++)
        bcd_in[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      dp_in = 4'($urandom_range(0, 15));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
